ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter_pkg.sv | 19 +
 rtl/ram_arbiter_arb_pick.sv | 36 +++
 rtl/ram_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared types and default sizing for the two-master RAM arbiter.
package ram_arbiter_pkg;

  localparam int ADDRW_DEF   = 4;
  localparam int DATAW_DEF   = 8;
  localparam int LOCKMAX_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  typedef enum logic {
    OWNC = 1'b0,
    OWNL = 1'b1
  } owner_t;

endpackage

// File: rtl/ram_arbiter_arb_pick.sv
// Combinational CPU/loader tie breaker. RAM_ARBITER_RR_EN selects round-robin
// on ties; otherwise the CPU always wins a tie.
module arb_pick
  import ram_arbiter_pkg::*;
(
  input  logic   creq,
  input  logic   lreq,
  input  owner_t lastowner,
  output owner_t winner,
  output logic   valid
);

  assign valid = creq | lreq;

`ifdef RAM_ARBITER_RR_EN
  always_comb begin
    winner = OWNC;
    if (creq && lreq) begin
      winner = (lastowner == OWNC) ? OWNL : OWNC;
    end else if (lreq) begin
      winner = OWNL;
    end
  end
`else
  logic unused_lastowner;
  assign unused_lastowner = lastowner;

  always_comb begin
    winner = OWNC;
    if (lreq && !creq) begin
      winner = OWNL;
    end
  end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Two-master (CPU, loader) arbiter in front of a synchronous-read RAM port,
// with loader burst lock bounded by LOCKMAX. Tie policy: RAM_ARBITER_RR_EN.
//
// state  | meaning
// IDLE   | no transfer; sample requests, register winner's fields
// GRANT  | RAM address/data/we driven, owner's gnt high
// ACCESS | RAM read data returns, owner's done high; locked loader may chain
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDRW   = ADDRW_DEF,
  parameter int DATAW   = DATAW_DEF,
  parameter int LOCKMAX = LOCKMAX_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             creq,
  input  logic             cwe,
  input  logic [ADDRW-1:0] caddr,
  input  logic [DATAW-1:0] cwdata,
  output logic             cgnt,
  output logic             cdone,
  output logic [DATAW-1:0] crdata,
  input  logic             lreq,
  input  logic             lwe,
  input  logic             llock,
  input  logic [ADDRW-1:0] laddr,
  input  logic [DATAW-1:0] lwdata,
  output logic             lgnt,
  output logic             ldone,
  output logic [DATAW-1:0] lrdata,
  output logic [ADDRW-1:0] maddr,
  output logic [DATAW-1:0] mwdata,
  output logic             mwe,
  input  logic [DATAW-1:0] mrdata,
  output logic             busy
);

  localparam int LCW = $clog2(LOCKMAX + 1);
  localparam logic [LCW-1:0] LOCK_TC = LCW'(LOCKMAX);

  state_t           state, state_nxt;
  owner_t           owner, lastowner, pick_w, load_own;
  logic             pick_v, load, cpu_forced;
  logic [ADDRW-1:0] r_addr;
  logic [DATAW-1:0] r_wdata;
  logic             r_we;
  logic [LCW-1:0]   lockcnt, lockcnt_nxt, lock_inc;

  arb_pick u_pick (
    .creq      (creq),
    .lreq      (lreq),
    .lastowner (lastowner),
    .winner    (pick_w),
    .valid     (pick_v)
  );

  // Saturating so an uncontested lock burst cannot wrap back below the limit
  assign lock_inc   = (lockcnt == LOCK_TC) ? lockcnt : lockcnt + LCW'(1);
  assign cpu_forced = creq && (lockcnt == LOCK_TC);

  always_comb begin
    state_nxt   = state;
    load        = 1'b0;
    load_own    = pick_w;
    lockcnt_nxt = lockcnt;
    case (state)
      IDLE: begin
        if (pick_v) begin
          load      = 1'b1;
          load_own  = cpu_forced ? OWNC : pick_w;
          state_nxt = GRANT;
        end
      end
      GRANT: state_nxt = ACCESS;
      ACCESS: begin
        state_nxt = IDLE;
        if (owner == OWNL) begin
          lockcnt_nxt = llock ? lock_inc : '0;
          if (llock && lreq && !((lock_inc == LOCK_TC) && creq)) begin
            load      = 1'b1;
            load_own  = OWNL;
            state_nxt = GRANT;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (load && (load_own == OWNC)) begin
      lockcnt_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      owner     <= OWNC;
      lastowner <= OWNL;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_we      <= 1'b0;
      lockcnt   <= '0;
      crdata    <= '0;
      lrdata    <= '0;
    end else begin
      state   <= state_nxt;
      lockcnt <= lockcnt_nxt;
      if (load) begin
        owner     <= load_own;
        lastowner <= load_own;
        r_addr    <= (load_own == OWNC) ? caddr  : laddr;
        r_wdata   <= (load_own == OWNC) ? cwdata : lwdata;
        r_we      <= (load_own == OWNC) ? cwe    : lwe;
      end
      if ((state == ACCESS) && !r_we) begin
        if (owner == OWNC) crdata <= mrdata;
        else               lrdata <= mrdata;
      end
    end
  end

  // Field registers only move on GRANT entry, so the RAM bus holds otherwise
  assign maddr  = r_addr;
  assign mwdata = r_wdata;
  assign mwe    = (state == GRANT) && r_we;
  assign cgnt   = (state == GRANT)  && (owner == OWNC);
  assign lgnt   = (state == GRANT)  && (owner == OWNL);
  assign cdone  = (state == ACCESS) && (owner == OWNC);
  assign ldone  = (state == ACCESS) && (owner == OWNL);
  assign busy   = (state != IDLE);

endmodule
